// File: rtl/fadd_fsub_unit.sv
// Binary32 FADD.S/FSUB.S unit: round-to-nearest-even with flush-to-zero.
// One registered result per enabled cycle, latency one edge.
module fadd_fsub_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            En,
   input  logic            Funct,
   input  logic [XLEN-1:0] frs1,
   input  logic [XLEN-1:0] frs2,
   output logic [XLEN-1:0] frd
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        sa, sb;
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_nan, b_nan, a_inf, b_inf;
   logic        a_zero, b_zero;
   logic [30:0] mag_a, mag_b;

   // Subtraction is addition of frs2 with its sign inverted
   assign sa = frs1[31];
   assign sb = frs2[31] ^ Funct;
   assign ea = frs1[30:23];
   assign eb = frs2[30:23];
   assign fa = frs1[22:0];
   assign fb = frs2[22:0];

   assign a_nan  = (ea == 8'hFF) && (fa != '0);
   assign b_nan  = (eb == 8'hFF) && (fb != '0);
   assign a_inf  = (ea == 8'hFF) && (fa == '0);
   assign b_inf  = (eb == 8'hFF) && (fb == '0);
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);

   // Subnormals collapse to zero magnitude here
   assign mag_a = a_zero ? '0 : frs1[30:0];
   assign mag_b = b_zero ? '0 : frs2[30:0];

   logic        swap;
   logic        sl, ss;
   logic [30:0] mag_l, mag_s;
   logic [7:0]  el, es, d;
   logic [23:0] ml, ms;

   assign swap  = mag_b > mag_a;
   assign sl    = swap ? sb : sa;
   assign ss    = swap ? sa : sb;
   assign mag_l = swap ? mag_b : mag_a;
   assign mag_s = swap ? mag_a : mag_b;
   assign el    = mag_l[30:23];
   assign es    = mag_s[30:23];
   assign ml    = {|el, mag_l[22:0]};
   assign ms    = {|es, mag_s[22:0]};
   assign d     = el - es;

   logic [26:0] ext_l, ext_s, sh_s, mask, al;

   assign ext_l = {ml, 3'b000};
   assign ext_s = {ms, 3'b000};

   always_comb begin
      sh_s = '0;
      mask = '0;
      al   = '0;
      if (d >= 8'd27) begin
         al = {26'd0, |ms};
      end else begin
         sh_s = ext_s >> d;
         mask = (27'd1 << d) - 27'd1;
         al   = {sh_s[26:1], sh_s[0] | (|(ext_s & mask))};
      end
   end

   logic        eff_sub;
   logic [27:0] sum;
   logic [26:0] diff;
   logic [4:0]  lz;
   logic        lz_found;

   assign eff_sub = sl ^ ss;
   assign sum     = {1'b0, ext_l} + {1'b0, al};
   assign diff    = ext_l - al;

   always_comb begin
      lz       = '0;
      lz_found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!lz_found && diff[i]) begin
            lz       = 5'(26 - i);
            lz_found = 1'b1;
         end
      end
   end

   logic [26:0] mant;
   logic [9:0]  exp_n;

   // exp_n wraps below zero; bit 9 then flags underflow
   always_comb begin
      mant  = '0;
      exp_n = '0;
      if (!eff_sub) begin
         if (sum[27]) begin
            mant  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, el} + 10'd1;
         end else begin
            mant  = sum[26:0];
            exp_n = {2'b00, el};
         end
      end else begin
         mant  = diff << lz;
         exp_n = {2'b00, el} - {5'd0, lz};
      end
   end

   logic        rnd_up;
   logic [24:0] m25;
   logic [9:0]  exp_r;
   logic [22:0] frac_r;
   logic        ovf, unf, cancel;

   assign rnd_up = mant[2] & (mant[1] | mant[0] | mant[3]);
   assign m25    = {1'b0, mant[26:3]} + {24'd0, rnd_up};

   always_comb begin
      if (m25[24]) begin
         exp_r  = exp_n + 10'd1;
         frac_r = m25[23:1];
      end else begin
         exp_r  = exp_n;
         frac_r = m25[22:0];
      end
   end

   assign cancel = eff_sub && (diff == '0);
   assign unf    = exp_r[9] || (exp_r == '0);
   assign ovf    = !exp_r[9] && (exp_r >= 10'd255);

   logic [31:0] res;

   always_comb begin
      if (a_nan || b_nan)
         res = QNAN;
      else if (a_inf && b_inf && (sa != sb))
         res = QNAN;
      else if (a_inf)
         res = {sa, 8'hFF, 23'd0};
      else if (b_inf)
         res = {sb, 8'hFF, 23'd0};
      else if (a_zero && b_zero)
         res = {sa & sb, 31'd0};
      else if (cancel)
         res = 32'h0000_0000;
      else if (ovf)
         res = {sl, 8'hFF, 23'd0};
      else if (unf)
         res = {sl, 31'd0};
      else
         res = {sl, exp_r[7:0], frac_r};
   end

   always_ff @(posedge clk) begin
      if (rst)
         frd <= '0;
      else if (En)
         frd <= res;
   end

endmodule

// File: tb/tb_fadd_fsub_unit.sv
// Self-checking bench for fadd_fsub_unit.
// Directed vectors plus random ops against an exact-arithmetic model.
module tb_fadd_fsub_unit;

   logic        clk;
   logic        rst;
   logic        En;
   logic        Funct;
   logic [31:0] frs1;
   logic [31:0] frs2;
   logic [31:0] frd;

   int passed = 0;
   int total  = 0;

   fadd_fsub_unit #(.XLEN(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .En   (En),
      .Funct(Funct),
      .frs1 (frs1),
      .frs2 (frs2),
      .frd  (frd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int W = 300;

   // Exact value of each operand as an integer in units of 2^-149,
   // summed exactly, then rounded to nearest-even at binary32 precision.
   function automatic logic [31:0] ref_op(input logic [31:0] a,
                                          input logic [31:0] b0,
                                          input logic        f);
      logic [31:0] b;
      logic        an, bn, ai, bi, az, bz, neg, up;
      logic [W-1:0] xu, yu, mag, rem, half, one;
      logic signed [W-1:0] x, y, s;
      logic [23:0] man;
      logic [24:0] m;
      int p, sh, e;
      b  = {b0[31] ^ f, b0[30:0]};
      an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      az = (a[30:23] == 8'h00);
      bz = (b[30:23] == 8'h00);
      if (an || bn) return 32'h7FC0_0000;
      if (ai && bi) return (a[31] == b[31]) ? a : 32'h7FC0_0000;
      if (ai) return a;
      if (bi) return b;
      if (az && bz) return {a[31] & b[31], 31'd0};
      one = 1;
      xu = '0;
      yu = '0;
      if (!az) xu = {{(W-24){1'b0}}, 1'b1, a[22:0]} << (a[30:23] - 8'd1);
      if (!bz) yu = {{(W-24){1'b0}}, 1'b1, b[22:0]} << (b[30:23] - 8'd1);
      x = a[31] ? -$signed(xu) : $signed(xu);
      y = b[31] ? -$signed(yu) : $signed(yu);
      s = x + y;
      if (s == 0) return 32'h0000_0000;
      neg = (s < 0);
      mag = neg ? W'(-s) : W'(s);
      p = -1;
      for (int i = 0; i < W; i++)
         if (mag[i]) p = i;
      if (p < 23) return {neg, 31'd0};
      sh   = p - 23;
      man  = 24'(mag >> sh);
      rem  = mag & ((one << sh) - one);
      half = (sh > 0) ? (one << (sh - 1)) : '0;
      up   = (sh > 0) && ((rem > half) || ((rem == half) && man[0]));
      m    = {1'b0, man} + {24'd0, up};
      e    = p - 22;
      if (m[24]) begin
         e = e + 1;
         m = m >> 1;
      end
      if (e >= 255) return {neg, 8'hFF, 23'd0};
      return {neg, 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp(input int base_e);
      logic [7:0] e;
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0)
         e = 8'hFF;
      else if (sel == 1)
         e = 8'h00;
      else if (sel == 2)
         e = 8'hFE;
      else if (sel == 3)
         e = 8'h01;
      else if (sel < 12 && base_e > 0)
         e = 8'(base_e + $urandom_range(0, 60) - 30 > 254 ? 254 :
                (base_e + int'($urandom_range(0, 60)) - 30 < 1 ? 1 :
                 base_e + int'($urandom_range(0, 4)) - 2));
      else
         e = 8'($urandom_range(1, 254));
      return {1'($urandom), e, 23'($urandom)};
   endfunction

   task automatic drive(input logic en, input logic fn,
                        input logic [31:0] a, input logic [31:0] b);
      En    = en;
      Funct = fn;
      frs1  = a;
      frs2  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b0, 32'h4020_0000, 32'h3FA0_0000);
      total++;
      if (frd !== 32'h0) $display("FAIL reset frd=%h want=00000000", frd);
      else passed++;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'h4020_0000, 32'h3FA0_0000);
         total++;
         if (frd !== 32'h0) $display("FAIL en_low_hold frd=%h want=00000000", frd);
         else passed++;
      end
   endtask

   task automatic test_directed();
      logic [31:0] va[18] = '{
         32'h4020_0000, 32'hC020_0000, 32'h4020_0000, 32'hC020_0000,
         32'hC020_0000, 32'h3FA0_0000, 32'h4020_0000, 32'h3F80_0000,
         32'h3F80_0000, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h7F80_0000,
         32'h7FC0_0001, 32'hFF80_0000, 32'h0000_0000, 32'h8000_0000,
         32'h0000_0000, 32'h0000_5555};
      logic [31:0] vb[18] = '{
         32'h0000_0000, 32'h3FA0_0000, 32'h0000_0000, 32'h3FA0_0000,
         32'hBFA0_0000, 32'hC020_0000, 32'h3FA0_0000, 32'h3F80_0000,
         32'h3380_0000, 32'h3380_0001, 32'h7F7F_FFFF, 32'h7F80_0000,
         32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h8000_0000,
         32'h8000_0000, 32'h8000_1234};
      logic vf[18] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
      logic [31:0] vr[18] = '{
         32'h4020_0000, 32'hBFA0_0000, 32'h4020_0000, 32'hC070_0000,
         32'hBFA0_0000, 32'h4070_0000, 32'h3FA0_0000, 32'h0000_0000,
         32'h3F80_0000, 32'h3F80_0001, 32'h7F80_0000, 32'h7FC0_0000,
         32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0000, 32'h8000_0000,
         32'h0000_0000, 32'h0000_0000};
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, vf[i], va[i], vb[i]);
         total++;
         if (frd !== vr[i])
            $display("FAIL directed[%0d] %h %s %h frd=%h want=%h",
                     i, va[i], vf[i] ? "-" : "+", vb[i], frd, vr[i]);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, want;
      logic        fn;
      for (int i = 0; i < 400; i++) begin
         a    = rand_fp(0);
         b    = rand_fp(int'(a[30:23]));
         fn   = 1'($urandom);
         want = ref_op(a, b, fn);
         drive(1'b1, fn, a, b);
         total++;
         if (frd !== want)
            $display("FAIL random[%0d] %h %s %h frd=%h want=%h",
                     i, a, fn ? "-" : "+", b, frd, want);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, want, prev;
      logic        fn;
      prev = frd;
      for (int i = 0; i < 20; i++) begin
         a    = rand_fp(0);
         b    = rand_fp(int'(a[30:23]));
         fn   = 1'($urandom);
         want = ref_op(a, b, fn);
         En = 1'b1; Funct = fn; frs1 = a; frs2 = b;
         #3;
         total++;
         if (frd !== prev) $display("FAIL latency[%0d] frd=%h want=%h", i, frd, prev);
         else passed++;
         @(posedge clk);
         #1;
         total++;
         if (frd !== want) $display("FAIL b2b[%0d] frd=%h want=%h", i, frd, want);
         else passed++;
         prev = want;
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'($urandom), rand_fp(0), rand_fp(0));
         total++;
         if (frd !== prev) $display("FAIL en_drop[%0d] frd=%h want=%h", i, frd, prev);
         else passed++;
      end
      drive(1'b1, 1'b0, 32'h4020_0000, 32'h3FA0_0000);
      total++;
      if (frd !== 32'h4070_0000) $display("FAIL resume frd=%h want=40700000", frd);
      else passed++;
      rst = 1'b1;
      drive(1'b1, 1'b0, 32'h3F80_0000, 32'h3F80_0000);
      rst = 1'b0;
      total++;
      if (frd !== 32'h0) $display("FAIL mid_reset frd=%h want=00000000", frd);
      else passed++;
   endtask

   initial begin
      rst = 1'b1; En = 1'b0; Funct = 1'b0; frs1 = '0; frs2 = '0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
